// File: rtl/mem_ctr_pkg.sv
// mem_ctr_pkg: bus-2 command and controller state types shared by the
// memory controller, its LFSR fill helper and the cache side.
package mem_ctr_pkg;

  typedef enum logic [1:0] {
    NOP        = 2'd0,
    RESPONSE   = 2'd1,
    READ_LINE  = 2'd2,
    WRITE_LINE = 2'd3
  } c2_cmd_e;

  typedef enum logic [2:0] {
    IDLE,
    WR_RECV,
    WR_WAIT,
    RESP,
    RD_WAIT,
    RD_SEND,
    INIT
  } state_e;

  localparam int BEAT_BYTES = 2;

  typedef logic [15:0] beat_t;

  // Galois form of x^16+x^14+x^13+x^11+1, shifting right
  function automatic logic [15:0] lfsr_step(logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

endpackage

// File: rtl/mem_ctr_lfsr.sv
// mem_ctr_lfsr: 16-bit Galois LFSR producing one line of fill bytes per
// step; byte j is the low byte after j single-byte steps.
module mem_ctr_lfsr
  import mem_ctr_pkg::*;
#(
  parameter logic [15:0] SEED  = 16'hACE1,
  parameter int          BYTES = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  load,
  input  logic                  step,
  output logic [BYTES-1:0][7:0] fill
);

  logic [15:0] st;
  logic [15:0] nxt;

  always_comb begin
    logic [15:0] s;
    s    = st;
    fill = '0;
    for (int i = 0; i < BYTES; i++) begin
      fill[i] = s[7:0];
      s       = lfsr_step(s);
    end
    nxt = s;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      st <= SEED;
    end else if (load) begin
      st <= SEED;
    end else if (step) begin
      st <= nxt;
    end
  end

endmodule

// File: rtl/mem_ctr_bus2.sv
// mem_ctr_bus2: bus-2 memory controller, line store with fixed-latency replies.
// Define MEM_CTR_LFSR_INIT_EN to LFSR-fill the whole array after each reset.
module mem_ctr_bus2
  import mem_ctr_pkg::*;
#(
  parameter int          ADDR2_W    = 10,
  parameter int          LINE_BYTES = 16,
  parameter int          MEM_DELAY  = 100,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [1:0]         c2_in,
  input  logic [ADDR2_W-1:0] a2_in,
  input  logic [15:0]        d2_in,
  output logic [1:0]         c2_out,
  output logic [15:0]        d2_out,
  output logic               bus2_oe
);

  localparam int BEATS = LINE_BYTES / BEAT_BYTES;
  localparam int LINES = 2 ** ADDR2_W;
  localparam int LW    = LINE_BYTES * 8;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int DW    = $clog2(MEM_DELAY + 1);

  localparam logic [BW-1:0] LAST = BW'(BEATS - 1);
  localparam logic [DW-1:0] FIRE = DW'(MEM_DELAY - 1);
  localparam logic [DW-1:0] DSAT = DW'(MEM_DELAY);

  if (LINE_BYTES % BEAT_BYTES != 0 || LINE_BYTES < BEAT_BYTES) begin : g_bad_line
    $error("LINE_BYTES must be even and nonzero");
  end
  if (MEM_DELAY < BEATS + 1) begin : g_bad_delay
    $error("MEM_DELAY must be at least BEATS+1");
  end
  if (LFSR_SEED == 16'h0) begin : g_bad_seed
    $error("a zero seed locks the LFSR");
  end

  state_e             state;
  c2_cmd_e            cmd;
  logic [ADDR2_W-1:0] addr;
  logic [ADDR2_W-1:0] wr_addr;
  logic [BW-1:0]      bcnt;
  logic [BW-1:0]      bnext;
  logic [DW-1:0]      dcnt;
  logic [DW-1:0]      dnext;
  logic [LW-1:0]      mem [LINES];
  logic [LW-1:0]      lbuf;
  logic [LW-1:0]      wr_line;
  logic [LW-1:0]      rd_line;
  logic               take_wr;
  logic               commit;

  function automatic beat_t beat_of(logic [LW-1:0] l, logic [BW-1:0] i);
    return l[16*int'(i) +: 16];
  endfunction

  assign cmd     = c2_cmd_e'(c2_in);
  assign bnext   = bcnt + 1'b1;
  assign dnext   = (dcnt == DSAT) ? dcnt : dcnt + 1'b1;
  assign rd_line = mem[addr];
  assign wr_addr = (state == IDLE) ? a2_in : addr;
  assign take_wr = !RESET && state == IDLE && cmd == WRITE_LINE;
  assign commit  = !RESET &&
                   ((state == WR_RECV && bcnt == LAST) ||
                    (take_wr && BEATS == 1));

  // last beat joins the buffered ones so the line lands in a single write
  always_comb begin
    wr_line              = lbuf;
    wr_line[LW-1 -: 16]  = d2_in;
  end

`ifdef MEM_CTR_LFSR_INIT_EN
  localparam state_e RST_STATE = INIT;

  logic [ADDR2_W-1:0]         icnt;
  logic [LINE_BYTES-1:0][7:0] fill;

  mem_ctr_lfsr #(
    .SEED  (LFSR_SEED),
    .BYTES (LINE_BYTES)
  ) u_lfsr (
    .CLK   (CLK),
    .RESET (RESET),
    .load  (1'b0),
    .step  (state == INIT),
    .fill  (fill)
  );
`else
  localparam state_e RST_STATE = IDLE;
`endif

  always_ff @(posedge CLK) begin
    if (take_wr) begin
      lbuf[15:0] <= d2_in;
    end else if (state == WR_RECV) begin
      lbuf[16*int'(bcnt) +: 16] <= d2_in;
    end
    if (commit) begin
      mem[wr_addr] <= wr_line;
    end
`ifdef MEM_CTR_LFSR_INIT_EN
    else if (state == INIT) begin
      mem[icnt] <= fill;
    end
`endif
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= RST_STATE;
      addr    <= '0;
      bcnt    <= '0;
      dcnt    <= '0;
      bus2_oe <= 1'b0;
      c2_out  <= NOP;
      d2_out  <= '0;
`ifdef MEM_CTR_LFSR_INIT_EN
      icnt    <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          bcnt <= '0;
          dcnt <= '0;
          if (cmd == READ_LINE) begin
            addr  <= a2_in;
            dcnt  <= DW'(1);
            state <= RD_WAIT;
          end else if (cmd == WRITE_LINE) begin
            addr  <= a2_in;
            dcnt  <= DW'(1);
            bcnt  <= BW'(1);
            state <= (BEATS == 1) ? WR_WAIT : WR_RECV;
          end
        end
        WR_RECV: begin
          dcnt <= dnext;
          bcnt <= bnext;
          if (bcnt == LAST) begin
            bcnt  <= '0;
            state <= WR_WAIT;
          end
        end
        WR_WAIT: begin
          dcnt <= dnext;
          if (dcnt == FIRE) begin
            state   <= RESP;
            bus2_oe <= 1'b1;
            c2_out  <= RESPONSE;
          end
        end
        RESP: begin
          dcnt    <= '0;
          bus2_oe <= 1'b0;
          c2_out  <= NOP;
          state   <= IDLE;
        end
        RD_WAIT: begin
          dcnt <= dnext;
          if (dcnt == FIRE) begin
            state   <= RD_SEND;
            bus2_oe <= 1'b1;
            c2_out  <= RESPONSE;
            d2_out  <= beat_of(rd_line, '0);
            bcnt    <= '0;
          end
        end
        RD_SEND: begin
          dcnt <= dnext;
          if (bcnt == LAST) begin
            bcnt    <= '0;
            dcnt    <= '0;
            bus2_oe <= 1'b0;
            c2_out  <= NOP;
            d2_out  <= '0;
            state   <= IDLE;
          end else begin
            bcnt   <= bnext;
            d2_out <= beat_of(rd_line, bnext);
          end
        end
`ifdef MEM_CTR_LFSR_INIT_EN
        INIT: begin
          icnt <= icnt + 1'b1;
          if (&icnt) begin
            state <= IDLE;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctr_bus2.sv
// tb_mem_ctr_bus2: randomized bus-2 traffic against a byte-array model;
// expected responses are queued at issue and popped by a bus monitor.
module tb_mem_ctr_bus2;
  import mem_ctr_pkg::*;

  localparam int AW  = 10;
  localparam int LB  = 16;
  localparam int DLY = 100;
  localparam int NB  = LB / 2;

  logic          CLK = 1'b0;
  logic          RESET;
  logic [1:0]    c2_in;
  logic [AW-1:0] a2_in;
  logic [15:0]   d2_in;
  logic [1:0]    c2_out;
  logic [15:0]   d2_out;
  logic          bus2_oe;

  mem_ctr_bus2 #(
    .ADDR2_W    (AW),
    .LINE_BYTES (LB),
    .MEM_DELAY  (DLY),
    .LFSR_SEED  (16'hACE1)
  ) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .c2_in   (c2_in),
    .a2_in   (a2_in),
    .d2_in   (d2_in),
    .c2_out  (c2_out),
    .d2_out  (d2_out),
    .bus2_oe (bus2_oe)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [1:0]  c2;
    logic [15:0] d;
  } exp_t;

  exp_t       sbq[$];
  logic [7:0] ref_mem [1<<AW][LB];
  int         wr_lines[$];
  int         vectors = 0;
  int         miscompares = 0;
  int         next_ok = 0;

  function automatic void check(string n, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", n, act, exp, cyc);
    end
  endfunction

  // monitor: every cycle the DUT owns the bus must match the queue head
  always @(negedge CLK) begin
    if (RESET !== 1'b1) begin
      if (bus2_oe !== 1'b0) begin
        if (sbq.size() == 0) begin
          check("spurious_oe", 64'(bus2_oe), 64'd0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("resp_cycle", 64'(cyc), 64'(e.cyc));
          check("resp_c2", 64'(c2_out), 64'(e.c2));
          check("resp_d2", 64'(d2_out), 64'(e.d));
        end
      end else if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
        check("missing_resp", 64'(bus2_oe), 64'd1);
        void'(sbq.pop_front());
      end
    end
  end

  // protocol watch: a command while the controller is still busy
  always @(negedge CLK) begin
    if (RESET === 1'b0 && c2_in != NOP && cyc < next_ok)
      $display("note: bus-2 command at cycle %0d while controller busy", cyc);
  end

  task automatic go_cycle(int c);
    while (cyc < c) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    sbq.delete();
    c2_in = NOP;
    d2_in = '0;
    #1;
    check("rst_oe", 64'(bus2_oe), 64'd0);
    check("rst_c2", 64'(c2_out), 64'(NOP));
    check("rst_d2", 64'(d2_out), 64'd0);
    repeat (2) @(posedge CLK);
    #3;
    RESET = 1'b0;
    @(posedge CLK);
    #1;
    check("post_rst_oe", 64'(bus2_oe), 64'd0);
    next_ok = cyc;
`ifdef MEM_CTR_LFSR_INIT_EN
    next_ok = cyc + (1 << AW) + 2;
`endif
  endtask

  task automatic issue_write(int a, input logic [7:0] b [LB], int abort);
    int t;
    go_cycle(next_ok);
    t     = cyc;
    c2_in = WRITE_LINE;
    a2_in = AW'(a);
    d2_in = {b[1], b[0]};
    for (int k = 1; k < NB; k++) begin
      @(posedge CLK);
      #1;
      c2_in = NOP;
      if (k == abort) begin
        do_reset();
        return;
      end
      d2_in = {b[2*k+1], b[2*k]};
    end
    @(posedge CLK);
    #1;
    d2_in = '0;
    for (int j = 0; j < LB; j++) ref_mem[a][j] = b[j];
    wr_lines.push_back(a);
    sbq.push_back('{t + DLY, RESPONSE, 16'h0});
    next_ok = t + DLY + 1;
  endtask

  task automatic issue_read(int a, bit abort);
    int t;
    go_cycle(next_ok);
    t     = cyc;
    c2_in = READ_LINE;
    a2_in = AW'(a);
    for (int k = 0; k < NB; k++)
      sbq.push_back('{t + DLY + k, RESPONSE,
                      {ref_mem[a][2*k+1], ref_mem[a][2*k]}});
    @(posedge CLK);
    #1;
    c2_in   = NOP;
    next_ok = t + DLY + NB;
    if (abort) begin
      go_cycle(t + DLY + 3);
      do_reset();
    end
  endtask

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b [LB];
    logic [7:0] inv [LB];
    c2_in = NOP;
    a2_in = '0;
    d2_in = '0;
    do_reset();

    // directed write/read of line 0x012, read back-to-back after RESP
    for (int j = 0; j < LB; j++) b[j] = 8'(j);
    issue_write(12'h012, b, -1);
    issue_read(12'h012, 1'b0);

    // stray command during RD_WAIT must be ignored
    issue_read(12'h012, 1'b0);
    c2_in = READ_LINE;
    a2_in = AW'(12'h100);
    @(posedge CLK);
    #1;
    c2_in = NOP;

    // random traffic
    for (int n = 0; n < 16; n++) begin
      next_ok += $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1 || wr_lines.size() == 0) begin
        for (int j = 0; j < LB; j++) b[j] = 8'($urandom);
        issue_write(int'($urandom_range(0, (1 << AW) - 1)), b, -1);
      end else begin
        issue_read(wr_lines[$urandom_range(0, wr_lines.size() - 1)], 1'b0);
      end
    end

    // top-address boundary
    for (int j = 0; j < LB; j++) begin
      b[j]   = 8'($urandom);
      inv[j] = ~b[j];
    end
    issue_write(12'h3FF, b, -1);
    issue_write(12'h000, inv, -1);
    issue_read(12'h000, 1'b0);
    issue_read(12'h3FF, 1'b0);

    // reset mid-write leaves the line untouched
    for (int j = 0; j < LB; j++) begin
      b[j]   = 8'hAA;
      inv[j] = 8'h55;
    end
    issue_write(12'h020, b, -1);
    issue_write(12'h020, inv, 4);
    issue_read(12'h020, 1'b0);

    // reset mid-read drops ownership at once, then normal service resumes
    issue_read(12'h012, 1'b1);
    issue_read(12'h012, 1'b0);

    go_cycle(next_ok + 2);
    check("drain", 64'(sbq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
